sb_config_ctrl: RTL and testbench
=================================

SB_CONFIG_CTRL -- requirements
Module: sb_config_ctrl

Interface
REQ-001 SHALL have parameter NUM_TILES, default 16, number of switch boxes driven.
REQ-002 SHALL have parameter ADDR_W, default 4, tile-address width; SHALL satisfy 2**ADDR_W >= NUM_TILES.
REQ-003 SHALL have parameter DATA_W, default 32, configuration word width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles after each write; 0 is legal.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports are listed below.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  pulse that begins a load session.
REQ-009 abort  input  1  pulse that terminates the session.
REQ-010 num_words  input  16  number of words expected in the session; sampled on an accepted start.
REQ-011 cfg_valid  input  1  configuration word available.
REQ-012 cfg_ready  output  1  controller accepts a word this cycle.
REQ-013 cfg_addr  input  ADDR_W  target tile index.
REQ-014 cfg_data  input  DATA_W  configuration word.
REQ-015 config_data  output  DATA_W  shared configuration bus to all switch boxes.
REQ-016 config_en  output  NUM_TILES  one-hot per-tile write strobe.
REQ-017 busy  output  1  session in progress.
REQ-018 done  output  1  session completed.
REQ-019 err  output  1  sticky; set on an out-of-range address.
REQ-020 words_written  output  16  number of committed writes in the current session.

Function
REQ-021 SHALL implement the states IDLE, ARMED, WRITE, SETTLE and DONE.
REQ-022 In IDLE or DONE, start SHALL latch num_words, clear words_written, err and done, and move to ARMED; if num_words==0 it SHALL move to DONE instead.
REQ-023 start in ARMED, WRITE or SETTLE SHALL be ignored.
REQ-024 cfg_ready SHALL be 1 only in ARMED, decoded from the state register, and SHALL NOT depend combinationally on cfg_valid.
REQ-025 A handshake (cfg_valid & cfg_ready) with cfg_addr < NUM_TILES SHALL register cfg_data onto config_data and move to WRITE.
REQ-026 A handshake with cfg_addr >= NUM_TILES SHALL set err, discard the word, leave words_written unchanged and remain in ARMED.
REQ-027 In WRITE, config_en SHALL be one-hot at the latched address for exactly one cycle (handshake at edge n -> config_en high in cycle n+1), and words_written SHALL increment by 1.
REQ-028 config_data SHALL remain stable from the WRITE cycle through the end of SETTLE.
REQ-029 WRITE SHALL be followed by SETTLE_CYCLES cycles in SETTLE; with SETTLE_CYCLES==0, SETTLE SHALL be skipped.
REQ-030 After the settle period, the FSM SHALL move to DONE if words_written==num_words, otherwise to ARMED.
REQ-031 busy SHALL be 1 in ARMED, WRITE and SETTLE.
REQ-032 done SHALL be 1 in DONE and held until the next accepted start or reset.
REQ-033 abort SHALL force IDLE on the next edge from any state and SHALL take priority over start and the handshake.
REQ-034 An abort in WRITE SHALL still allow that cycle's config_en pulse; no further config_en SHALL be issued.
REQ-035 abort SHALL leave err and words_written unchanged.
REQ-036 config_en SHALL be all-zero in every state except WRITE.
REQ-037 words_written SHALL saturate at 16'hFFFF.

Reset
REQ-038 Asserting reset low SHALL immediately force state IDLE and set all outputs to 0: config_data, config_en, cfg_ready, busy, done, err and words_written.
REQ-039 A reset asserted mid-session SHALL abandon the session with no further config_en; the session SHALL NOT resume after reset deasserts.

Structure
REQ-040 A shared package sb_ctrl_pkg SHALL hold the state enum and the default values of NUM_TILES, ADDR_W, DATA_W and SETTLE_CYCLES.
REQ-041 The address-to-one-hot decode SHALL be a sub-module, sb_addr_decode.
REQ-042 The design SHALL contain no other sub-modules.

Verification
REQ-043 Scenario: reset, then num_words=2, start, then words (addr 3, 0xDEADBEEF) and (addr 15, 0x12345678) with valid held -> config_en=0x0008 then 0x8000, each for one cycle, spaced by 3 cycles; words_written=2; done=1.
REQ-044 Scenario: num_words=1, a word with addr 20 (NUM_TILES=16) followed by a word with addr 1 -> err=1, config_en=0x0002 once, done=1.
REQ-045 Scenario: start with num_words=0 -> done=1 one cycle later; busy never set; config_en stays 0.
REQ-046 Scenario: abort asserted during SETTLE after the first of 3 words -> IDLE; words_written=1; no further config_en; a subsequent start is accepted.
REQ-047 Scenario: reset pulsed low while in WRITE -> all outputs 0 immediately, state IDLE, cfg_ready=0.
REQ-048 Scenario: start pulsed during ARMED with a new num_words -> ignored; the original count still governs done.

Source files
------------

// File: rtl/sb_ctrl_pkg.sv
// Shared types and default parameters for the switch-box
// configuration controller.
package sb_ctrl_pkg;

   localparam int NUM_TILES_DEF     = 16;
   localparam int ADDR_W_DEF        = 4;
   localparam int DATA_W_DEF        = 32;
   localparam int SETTLE_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WRITE,
      ST_SETTLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sb_addr_decode.sv
// Tile address to one-hot write strobe, gated by an enable.
module sb_addr_decode #(
   parameter int NUM_TILES = 16,
   parameter int ADDR_W    = 4
) (
   input  logic [ADDR_W-1:0]    addr,
   input  logic                 en,
   output logic [NUM_TILES-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (en && (addr == ADDR_W'(i))) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sb_config_ctrl.sv
// Session controller that streams configuration words onto a shared
// bus and strobes one switch box per committed word.
module sb_config_ctrl
   import sb_ctrl_pkg::*;
#(
   parameter int NUM_TILES     = NUM_TILES_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [15:0]          num_words,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [ADDR_W-1:0]    cfg_addr,
   input  logic [DATA_W-1:0]    cfg_data,
   output logic [DATA_W-1:0]    config_data,
   output logic [NUM_TILES-1:0] config_en,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [15:0]          words_written
);

   localparam logic [15:0] SETTLE_LAST =
      16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   state_t              state;
   state_t              state_nx;
   logic [15:0]         num_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         settle_cnt;
   logic [15:0]         ww_inc;
   logic                hs;
   logic                in_range;
   logic                idle_like;
   logic                settle_last;

   assign hs          = cfg_valid & cfg_ready;
   assign in_range    = 32'(cfg_addr) < NUM_TILES;
   assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
   assign settle_last = settle_cnt == SETTLE_LAST;
   assign ww_inc      = (words_written == 16'hFFFF) ?
                        words_written : words_written + 16'd1;

   assign cfg_ready = state == ST_ARMED;
   assign done      = state == ST_DONE;
   assign busy      = (state == ST_ARMED) ||
                      (state == ST_WRITE) ||
                      (state == ST_SETTLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_nx = (num_words == 16'd0) ? ST_DONE : ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (hs && in_range) begin
                  state_nx = ST_WRITE;
               end
            end
            ST_WRITE: begin
               // With no settle period the completion test uses the
               // count as it will be after this write commits.
               if (SETTLE_CYCLES == 0) begin
                  state_nx = (ww_inc == num_q) ? ST_DONE : ST_ARMED;
               end else begin
                  state_nx = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_last) begin
                  state_nx = (words_written == num_q) ? ST_DONE : ST_ARMED;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_q         <= '0;
         addr_q        <= '0;
         config_data   <= '0;
         words_written <= '0;
         err           <= 1'b0;
         settle_cnt    <= '0;
      end else begin
         if (!abort && idle_like && start) begin
            num_q         <= num_words;
            words_written <= '0;
            err           <= 1'b0;
         end
         if (!abort && (state == ST_ARMED) && hs) begin
            if (in_range) begin
               config_data <= cfg_data;
               addr_q      <= cfg_addr;
            end else begin
               err <= 1'b1;
            end
         end
         if (!abort && (state == ST_WRITE)) begin
            words_written <= ww_inc;
         end
         if (state == ST_WRITE) begin
            settle_cnt <= '0;
         end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 16'd1;
         end
      end
   end

   sb_addr_decode #(
      .NUM_TILES (NUM_TILES),
      .ADDR_W    (ADDR_W)
   ) u_addr_decode (
      .addr   (addr_q),
      .en     (state == ST_WRITE),
      .onehot (config_en)
   );

endmodule

// File: tb/tb_sb_config_ctrl.sv
// Scenario bench for sb_config_ctrl with a scoreboard of expected
// per-tile write strobes.
module tb_sb_config_ctrl;

   localparam int NT = 16;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [NT-1:0] en;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [15:0]   num_words = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic [DW-1:0] config_data;
   logic [NT-1:0] config_en;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   words_written;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   int   pulse_cyc[$];

   sb_config_ctrl #(
      .NUM_TILES     (NT),
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .num_words     (num_words),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_addr      (cfg_addr),
      .cfg_data      (cfg_data),
      .config_data   (config_data),
      .config_en     (config_en),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time expired, required finish");
      $fatal(1);
   end

   // Advance one cycle, sample just after the edge, and match any
   // strobe against the oldest expected write.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (config_en !== '0) begin
         checks++;
         pulse_cyc.push_back(cyc);
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: config_en=%h required none",
                     config_en);
         end else begin
            e = sb_q.pop_front();
            if (config_en !== e.en || config_data !== e.data) begin
               errors++;
               $display("FAIL write: en=%h data=%h required en=%h data=%h",
                        config_en, config_data, e.en, e.data);
            end
         end
      end
   endtask

   task automatic start_session(input logic [15:0] n);
      num_words = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      exp_t e;
      logic hs;
      logic got;
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      got = 1'b0;
      if (32'(a) < NT) begin
         e.en   = NT'(1) << a;
         e.data = d;
         sb_q.push_back(e);
      end
      for (int i = 0; i < 50 && !got; i++) begin
         hs = cfg_ready;
         tick();
         got = hs;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL handshake_timeout: cfg_ready=%b required 1",
                  cfg_ready);
      end
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max && done !== 1'b1; i++) begin
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b required 1", done);
      end
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d pending writes required 0",
                  name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks++;
      if ({cfg_ready, busy, done, err, words_written,
           config_en, config_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b busy=%b done=%b err=%b ww=%0d en=%h data=%h required all 0",
                  cfg_ready, busy, done, err, words_written,
                  config_en, config_data);
      end
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_two_words();
      start_session(16'd2);
      checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b1 || words_written !== 16'd0) begin
         errors++;
         $display("FAIL armed: busy=%b rdy=%b ww=%0d required 1 1 0",
                  busy, cfg_ready, words_written);
      end
      pulse_cyc.delete();
      send_word(5'd3, 32'hDEADBEEF);
      send_word(5'd15, 32'h12345678);
      cfg_valid = 1'b0;
      wait_done(20);
      check_sb_empty("two_words");
      checks++;
      if (words_written !== 16'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL two_words_count: ww=%0d busy=%b required 2 0",
                  words_written, busy);
      end
      // WRITE, two SETTLE cycles, ARMED, then the next WRITE.
      checks++;
      if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 4) begin
         errors++;
         $display("FAIL pulse_spacing: pulses=%0d required 2 pulses 4 cycles apart",
                  pulse_cyc.size());
      end
      checks++;
      if (config_data !== 32'h12345678) begin
         errors++;
         $display("FAIL data_hold: config_data=%h required 12345678",
                  config_data);
      end
   endtask

   task automatic test_bad_addr();
      start_session(16'd1);
      send_word(5'd20, 32'hAAAA0001);
      checks++;
      if (err !== 1'b1 || cfg_ready !== 1'b1 || words_written !== 16'd0) begin
         errors++;
         $display("FAIL bad_addr: err=%b rdy=%b ww=%0d required 1 1 0",
                  err, cfg_ready, words_written);
      end
      send_word(5'd1, 32'h0BADF00D);
      cfg_valid = 1'b0;
      wait_done(20);
      check_sb_empty("bad_addr");
      checks++;
      if (err !== 1'b1 || words_written !== 16'd1) begin
         errors++;
         $display("FAIL bad_addr_end: err=%b ww=%0d required 1 1",
                  err, words_written);
      end
   endtask

   task automatic test_zero_words();
      start_session(16'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 ||
          words_written !== 16'd0) begin
         errors++;
         $display("FAIL zero_words: done=%b busy=%b err=%b ww=%0d required 1 0 0 0",
                  done, busy, err, words_written);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_words_hold: busy=%b done=%b required 0 1",
                     busy, done);
         end
      end
   endtask

   task automatic test_abort();
      start_session(16'd3);
      send_word(5'd5, 32'h55555555);
      tick();
      cfg_addr = 5'd6;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0 ||
          words_written !== 16'd1) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b rdy=%b ww=%0d required 0 0 0 1",
                  busy, done, cfg_ready, words_written);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b required 0", busy);
         end
      end
      cfg_valid = 1'b0;
      start_session(16'd1);
      checks++;
      if (busy !== 1'b1 || words_written !== 16'd0) begin
         errors++;
         $display("FAIL abort_restart: busy=%b ww=%0d required 1 0",
                  busy, words_written);
      end
      send_word(5'd9, 32'h99990000);
      cfg_valid = 1'b0;
      wait_done(20);
      check_sb_empty("abort");
   endtask

   task automatic test_start_ignored();
      start_session(16'd2);
      num_words = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_in_armed: busy=%b rdy=%b required 1 1",
                  busy, cfg_ready);
      end
      send_word(5'd2, 32'h22220000);
      cfg_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (done !== 1'b0 || cfg_ready !== 1'b1 || words_written !== 16'd1) begin
         errors++;
         $display("FAIL start_ignored_mid: done=%b rdy=%b ww=%0d required 0 1 1",
                  done, cfg_ready, words_written);
      end
      send_word(5'd4, 32'h44440000);
      cfg_valid = 1'b0;
      wait_done(20);
      check_sb_empty("start_ignored");
      checks++;
      if (words_written !== 16'd2) begin
         errors++;
         $display("FAIL start_ignored_end: ww=%0d required 2", words_written);
      end
   endtask

   task automatic test_reset_mid_write();
      start_session(16'd2);
      send_word(5'd7, 32'h77777777);
      reset = 1'b0;
      #1;
      checks++;
      if ({cfg_ready, busy, done, err, words_written,
           config_en, config_data} !== '0) begin
         errors++;
         $display("FAIL reset_in_write: rdy=%b busy=%b done=%b err=%b ww=%0d en=%h data=%h required all 0",
                  cfg_ready, busy, done, err, words_written,
                  config_en, config_data);
      end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: busy=%b rdy=%b required 0 0",
                     busy, cfg_ready);
         end
      end
      cfg_valid = 1'b0;
      check_sb_empty("reset_mid");
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_bad_addr();
      test_zero_words();
      test_abort();
      test_start_ignored();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
